// File: rtl/go_done_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// go_done_pkg
// Shared definitions for the go/done arbiter slice: the controller state
// encoding, the default slow-tick divider and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package go_done_pkg;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_GO_HIGH   = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    // 12 MHz system clock divided down to a 20 Hz slow tick.
    localparam int DEFAULT_TICK_DIV = 600000;

    // Bits needed to hold the values 0..max_val-1; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/go_done_arbiter_if.sv
// -----------------------------------------------------------------------------
// go_done_arbiter_if
// Bundles the requester handshake (req/grant/reqDone/timeoutErr), the owner
// status (activeId/busy) and the worker handshake (workerGo/workerDone).
//   master : arbiter side  - drives grant, activeId, busy, workerGo,
//                            reqDone, timeoutErr; samples req, workerDone
//   slave  : client side   - drives req, workerDone; samples the rest
// Parameter N_REQ sets the number of requesters.
// -----------------------------------------------------------------------------
interface go_done_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  activeId;
    logic             busy;
    logic             workerGo;
    logic             workerDone;
    logic [N_REQ-1:0] reqDone;
    logic             timeoutErr;

    modport master (
        input  req,
        input  workerDone,
        output grant,
        output activeId,
        output busy,
        output workerGo,
        output reqDone,
        output timeoutErr
    );

    modport slave (
        output req,
        output workerDone,
        input  grant,
        input  activeId,
        input  busy,
        input  workerGo,
        input  reqDone,
        input  timeoutErr
    );

endinterface

// File: rtl/go_done_arbiter_tick.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running clock-enable generator. A counter runs 0..TICK_DIV-1 and tick
// is high for the single clk on which the counter sits at TICK_DIV-1, after
// which the counter wraps. Nothing stalls it, so every consumer of the tick
// sees the same slow time base.
// Ports:
//   clk   in   system clock
//   rstN  in   asynchronous active-low reset (counter returns to 0)
//   tick  out  one-clk-wide slow-tick enable
// -----------------------------------------------------------------------------
module tick_gen
    import go_done_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rstN,
    output logic tick
);

    localparam int             CW       = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/go_done_arbiter.sv
// -----------------------------------------------------------------------------
// go_done_arbiter
// Round-robin owner of a single go/done worker shared by N_REQ requesters.
// Per job: grant one requester, hold workerGo for GO_TICKS slow ticks, drop
// it, wait for a rising edge on workerDone (or TIMEOUT_TICKS slow ticks),
// then pulse reqDone for the owner (with timeoutErr on an abort).
// Ports:
//   clk   in  system clock (single domain)
//   rstN  in  asynchronous active-low reset
//   bus   go_done_arbiter_if.master:
//         req[N_REQ]      in   level requests
//         grant[N_REQ]    out  one-hot owner, zero when idle
//         activeId        out  index of current / last owner
//         busy            out  high while a job is in flight
//         workerGo        out  go level to the worker
//         workerDone      in   worker done level
//         reqDone[N_REQ]  out  one-clk completion pulse to the owner
//         timeoutErr      out  one-clk pulse alongside reqDone on abort
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no owner; round-robin pick on any request
// GO_HIGH    | workerGo held high, counting GO_TICKS slow ticks
// WAIT_DONE  | workerGo low, waiting for done rise or timeout
// RELEASE    | one clk: pulse reqDone, clear grant, remember owner
// -----------------------------------------------------------------------------
module go_done_arbiter
    import go_done_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int TICK_DIV      = DEFAULT_TICK_DIV,
    parameter int GO_TICKS      = 2,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                clk,
    input  logic                rstN,
    go_done_arbiter_if.master   bus
);

    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TC_MAX = (GO_TICKS > TIMEOUT_TICKS) ? GO_TICKS : TIMEOUT_TICKS;
    localparam int TC_W   = cnt_width(TC_MAX);

    localparam logic [TC_W-1:0] GO_LAST      = TC_W'(GO_TICKS - 1);
    localparam logic [TC_W-1:0] TIMEOUT_LAST = TC_W'(TIMEOUT_TICKS - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  last_id;
    logic [TC_W-1:0]  tick_cnt;
    logic             done_q;
    logic             abort_q;
    logic             tick;
    logic             done_rise;

    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  active_id_q;
    logic             busy_q;
    logic             worker_go_q;
    logic [N_REQ-1:0] req_done_q;
    logic             timeout_err_q;

    // First set request after 'last', wrapping modulo N_REQ. The scan runs
    // from the farthest candidate back to the nearest so the nearest wins.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [ID_W-1:0]  last
    );
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        pick = last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rstN (rstN),
        .tick (tick)
    );

    assign done_rise = bus.workerDone & ~done_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= ST_IDLE;
            last_id       <= ID_W'(N_REQ - 1);
            tick_cnt      <= '0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            grant_q       <= '0;
            active_id_q   <= '0;
            busy_q        <= 1'b0;
            worker_go_q   <= 1'b0;
            req_done_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q        <= bus.workerDone;
            req_done_q    <= '0;
            timeout_err_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        active_id_q <= rr_pick(bus.req, last_id);
                        grant_q     <= onehot(rr_pick(bus.req, last_id));
                        busy_q      <= 1'b1;
                        worker_go_q <= 1'b1;
                        tick_cnt    <= '0;
                        abort_q     <= 1'b0;
                        state       <= ST_GO_HIGH;
                    end
                end

                // A done rise here is the previous job's level still being
                // cleared by the worker, so it is deliberately not looked at.
                ST_GO_HIGH: begin
                    if (tick) begin
                        if (tick_cnt == GO_LAST) begin
                            worker_go_q <= 1'b0;
                            tick_cnt    <= '0;
                            state       <= ST_WAIT_DONE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                // Done is tested before the tick so a rise landing on the
                // final timeout tick completes the job normally.
                ST_WAIT_DONE: begin
                    if (done_rise) begin
                        abort_q <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (tick) begin
                        if (tick_cnt == TIMEOUT_LAST) begin
                            abort_q <= 1'b1;
                            state   <= ST_RELEASE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                // reqDone fires on an abort too; timeoutErr tells them apart.
                ST_RELEASE: begin
                    req_done_q    <= onehot(active_id_q);
                    timeout_err_q <= abort_q;
                    grant_q       <= '0;
                    busy_q        <= 1'b0;
                    last_id       <= active_id_q;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.activeId   = active_id_q;
    assign bus.busy       = busy_q;
    assign bus.workerGo   = worker_go_q;
    assign bus.reqDone    = req_done_q;
    assign bus.timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_go_done_arbiter.sv
module tb_go_done_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int GT = 2;
    localparam int TO = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    go_done_arbiter_if #(.N_REQ(N)) bus ();

    go_done_arbiter #(
        .N_REQ         (N),
        .TICK_DIV      (TD),
        .GO_TICKS      (GT),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; slow ticks land on multiples of TD.
    int cyc;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    int last_id = N - 1;
    int prev_r  = 0;
    bit gap_due = 1'b0;
    int g_edge  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (((r >> idx) & 4'b0001) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic int nth_tick(input int base, input int n);
        return ((base / TD) + 1) * TD + (n - 1) * TD;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    // One complete job. delay < 0: worker never raises done; otherwise done
    // rises after the edge delay clks past the workerGo fall edge.
    task automatic job(input logic [N-1:0] req_mid, input logic [N-1:0] req_next, input int delay);
        int n, g, f, r_exp, t_edge, seen, win;
        bit exp_err;
        n = 0;
        while (bus.grant == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant == 0) begin
            check("grant_seen", {31'd0, bus.grant != 0}, 1);
            return;
        end
        g      = cyc;
        g_edge = g;
        win    = pick(bus.req, last_id);
        if (gap_due) check("regrant_gap", g, prev_r + 1);
        check("grant", bus.grant, oh(win));
        check("active_id", bus.activeId, win);
        check("busy_on", bus.busy, 1);
        check("go_on", bus.workerGo, 1);
        bus.workerDone = 1'b0;
        bus.req        = req_mid;

        n = 0;
        while (bus.workerGo && n < 40) begin
            @(negedge clk);
            n++;
        end
        f = cyc;
        check("go_fall_edge", f, nth_tick(g, GT));
        check("grant_hold", bus.grant, oh(win));

        t_edge = nth_tick(f, TO);
        seen   = f + delay + 1;
        if (delay < 0 || seen > t_edge) begin
            r_exp   = t_edge + 1;
            exp_err = 1'b1;
        end else begin
            r_exp   = seen + 1;
            exp_err = 1'b0;
        end

        n = 0;
        while (n < 80) begin
            if (delay >= 0 && cyc == f + delay) bus.workerDone = 1'b1;
            if (bus.reqDone != 0 || bus.timeoutErr) break;
            @(negedge clk);
            n++;
        end
        check("release_edge", cyc, r_exp);
        check("req_done", bus.reqDone, oh(win));
        check("timeout_err", bus.timeoutErr, exp_err);
        check("busy_off", bus.busy, 0);
        check("grant_off", bus.grant, 0);
        check("go_off", bus.workerGo, 0);

        last_id = win;
        prev_r  = cyc;
        gap_due = (req_next != 0);
        bus.req = req_next;
        @(negedge clk);
        check("done_pulse", bus.reqDone, 0);
        check("err_pulse", bus.timeoutErr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rm, rn;
        int dl, n;

        bus.req        = '0;
        bus.workerDone = 1'b0;
        rstN           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", bus.grant, 0);
        check("rst_active_id", bus.activeId, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_go", bus.workerGo, 0);
        check("rst_req_done", bus.reqDone, 0);
        check("rst_timeout", bus.timeoutErr, 0);

        // First job straight out of reset
        bus.req = 4'b0001;
        rstN    = 1'b1;
        job(4'b0000, 4'b1111, 3);
        check("first_grant_edge", g_edge, 1);

        // All requesting: rotation
        for (int i = 0; i < 4; i++) job(4'b1111, 4'b1111, 3);
        job(4'b1111, 4'b0100, 3);

        // Worker silent -> timeout, then normal job with done on the timeout tick
        job(4'b0100, 4'b0001, -1);
        job(4'b0000, 4'b0000, 31);

        // Owner drops req mid-job, others pending
        bus.req = 4'b0100;
        job(4'b1010, 4'b1010, 5);
        job(4'b1010, 4'b0000, 3);

        // Randomized jobs
        for (int i = 0; i < 40; i++) begin
            if (bus.req == 0) bus.req = 4'($urandom_range(1, 15));
            rm = 4'($urandom);
            rn = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       dl = -1;
                1:       dl = TO * TD - 1;
                default: dl = $urandom_range(0, 40);
            endcase
            job(rm, rn, dl);
        end

        // Reset during WAIT_DONE
        if (bus.req == 0) bus.req = 4'b0100;
        n = 0;
        while (bus.grant == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        bus.workerDone = 1'b0;
        n = 0;
        while (bus.workerGo && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        #1 rstN = 1'b0;
        #1;
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_go", bus.workerGo, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_req_done", bus.reqDone, 0);
        bus.req = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_req_done", bus.reqDone, 0);
        end
        rstN    = 1'b1;
        last_id = N - 1;
        gap_due = 1'b0;
        job(4'b0000, 4'b0000, 3);
        check("post_rst_grant_edge", g_edge, 1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/go_done_arbiter.md
Name: go_done_arbiter

Overview:
- Round-robin controller that shares one go/done worker between N_REQ requesters.
- The worker is a counter FSM that advances on go and reports doneSig after go falls.
- Sequencing per job: grant one requester, assert workerGo for GO_TICKS slow ticks, drop workerGo, wait for the rising edge of workerDone, then pulse reqDone for that requester.
- Uses an internal clock-enable tick rather than a divided clock. Includes a done timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TICK_DIV, 600000, clk cycles per slow tick (12 MHz → 20 Hz).
- GO_TICKS, 2, slow ticks workerGo is held high (≥1).
- TIMEOUT_TICKS, 16, slow ticks to wait for workerDone before abort.

Ports:
- clk  in  1  12 MHz clock, single clock domain.
- rstN  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; clk-synchronous.
- grant  out  N_REQ  one-hot owner of the worker; all zero when idle.
- activeId  out  $clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high whenever state is not IDLE.
- workerGo  out  1  go to the worker; registered.
- workerDone  in  1  worker doneSig level; clk-synchronous.
- reqDone  out  N_REQ  one-cycle completion pulse to the owner.
- timeoutErr  out  1  one-cycle pulse when a job aborts on timeout.

Behaviour:
- Reset (rstN=0, asynchronous):
  - Outputs: grant=0, activeId=0, busy=0, workerGo=0, reqDone=0, timeoutErr=0.
  - Internal: state=IDLE, lastId=N_REQ-1 (req[0] has first priority), tick counter=0, tick-count=0, doneQ=0.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for one clk when the counter equals TICK_DIV-1, then it wraps to 0. The counter is never stalled by the FSM.
- Done edge: doneQ registers workerDone every clk. doneRise = workerDone & ~doneQ.
- All outputs are registered and change only on posedge clk.
- States are IDLE, GO_HIGH, WAIT_DONE, RELEASE.
- IDLE:
  - If any req bit is high, choose the first set bit searching lastId+1, lastId+2, … modulo N_REQ.
  - Next clk: grant=onehot(winner), activeId=winner, busy=1, workerGo=1, tick-count=0, state=GO_HIGH.
  - Arbitration-to-workerGo latency is 1 clk.
- GO_HIGH:
  - tick-count increments on each tick.
  - When tick=1 and tick-count==GO_TICKS-1: workerGo=0, tick-count=0, state=WAIT_DONE.
  - doneRise in this state is ignored. It is stale: the worker clears done only after seeing go.
- WAIT_DONE:
  - On doneRise: state=RELEASE.
  - Else on tick: tick-count increments. On reaching TIMEOUT_TICKS: timeoutErr=1 for 1 clk, state=RELEASE.
  - doneRise on the same clk as the timeout tick means done wins and no timeoutErr is raised.
- RELEASE (exactly 1 clk):
  - reqDone[activeId]=1 on timeout too; the requester tells the two cases apart via timeoutErr.
  - grant=0, busy=0, lastId=activeId, state=IDLE.
  - activeId holds its value.
- Requests during a job:
  - A req drop mid-job is ignored; the job runs to completion.
  - New reqs wait; no preemption.
  - A requester still holding req after its reqDone is served again only after every other pending requester has been served.
- Earliest re-grant is the clk after RELEASE, so there is a minimum 1 idle clk between jobs.
- workerGo and grant are never high in IDLE or RELEASE. Worker-visible go is guaranteed to span ≥GO_TICKS-1 full tick periods.
- Reset asserted mid-job drops workerGo and grant immediately (asynchronous) with no reqDone. The worker must share rstN.

Decomposition:
- Shared package go_done_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_GO_HIGH=2'd1, ST_WAIT_DONE=2'd2, ST_RELEASE=2'd3;
  - default TICK_DIV=600000.
- One sub-module, tick_gen (parameter TICK_DIV; ports clk, rstN, tick).
  - It replaces ad-hoc divided clocks; the worker should move to the same tick enable.
- Round-robin pick is a combinational function inside go_done_arbiter.

Test Plan:
(Bench parameters: N_REQ=4, TICK_DIV=4, GO_TICKS=2, TIMEOUT_TICKS=8. The worker model raises done 3 clk after go falls and holds it until the next go.)
- Reset release with req=0001 → grant=0001 and workerGo=1 one clk after sampling. workerGo falls on the 2nd tick. reqDone=0001 pulses 1 clk after doneRise. busy falls with it.
- req=1111 held continuously → grant order 0001, 0010, 0100, 1000, 0001. activeId goes 0, 1, 2, 3, 0. Exactly one reqDone per job.
- Worker never raises done → timeoutErr and reqDone[id] pulse together 8 ticks (32 clk) after workerGo falls. Next grant proceeds normally.
- doneRise on the same clk as the 8th timeout tick → reqDone pulses, timeoutErr stays 0.
- req[2] dropped during GO_HIGH → job completes and reqDone=0100 still pulses. With req=1010 pending, the next grant is 1000, not 0010.
- rstN pulled low during WAIT_DONE → grant, workerGo and busy are 0 within the same cycle with no reqDone. After release, req=0001 gets first grant.
